// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the cache/memory arbiter: FSM states, request
// source encoding and the address/line widths used on every port.
package cache_types_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of both caches' pmem-side signals plus the physical memory port.
// The arbiter connects through 'master', the caches/memory model through 'slave'.
interface cache_arbiter_if #(
  parameter int ADDR_W = cache_types_pkg::ADDR_W,
  parameter int LINE_W = cache_types_pkg::LINE_W
);

  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport slave (
    output i_address, i_read, d_address, d_read, d_write, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// Serialises icache/dcache line transactions onto one memory port, one at a time.
// Define CACHE_ARBITER_RR_EN for round-robin on collisions; default is fixed dcache priority.
module cache_arbiter #(
  parameter int ADDR_W = cache_types_pkg::ADDR_W,
  parameter int LINE_W = cache_types_pkg::LINE_W
) (
  input logic             clk,
  input logic             rst,
  cache_arbiter_if.master bus
);

  import cache_types_pkg::*;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;

  logic     i_req;
  logic     d_req;
  arb_src_t winner;

`ifdef CACHE_ARBITER_RR_EN
  arb_src_t last_winner_q, last_winner_d;
`endif

  // On a collision the loser of the previous grant wins; lone requests always win.
  always_comb begin
    i_req = bus.i_read;
    d_req = bus.d_read | bus.d_write;
`ifdef CACHE_ARBITER_RR_EN
    if (i_req && d_req) begin
      winner = (last_winner_q == SRC_I) ? SRC_D : SRC_I;
    end else begin
      winner = d_req ? SRC_D : SRC_I;
    end
`else
    winner = d_req ? SRC_D : SRC_I;
`endif
  end

  // pmem outputs come only from state and captured registers, never from cache inputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
`ifdef CACHE_ARBITER_RR_EN
    last_winner_d = last_winner_q;
`endif
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.i_resp       = 1'b0;
    bus.i_rdata      = '0;
    bus.d_resp       = 1'b0;
    bus.d_rdata      = '0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
`ifdef CACHE_ARBITER_RR_EN
          last_winner_d = winner;
`endif
          if (winner == SRC_D) begin
            state_d = SERVE_D;
            addr_d  = bus.d_address;
            write_d = bus.d_write;
            wdata_d = bus.d_write ? bus.d_wdata : '0;
          end else begin
            state_d = SERVE_I;
            addr_d  = bus.i_address;
            write_d = 1'b0;
            wdata_d = '0;
          end
        end
      end
      SERVE_I: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = addr_q;
        if (bus.pmem_resp) begin
          bus.i_resp  = 1'b1;
          bus.i_rdata = bus.pmem_rdata;
          state_d     = DONE;
        end
      end
      SERVE_D: begin
        bus.pmem_read    = ~write_q;
        bus.pmem_write   = write_q;
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = wdata_q;
        if (bus.pmem_resp) begin
          bus.d_resp  = 1'b1;
          bus.d_rdata = bus.pmem_rdata;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
`ifdef CACHE_ARBITER_RR_EN
      last_winner_q <= SRC_I;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
`ifdef CACHE_ARBITER_RR_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter; honours CACHE_ARBITER_RR_EN in its grant model.
// Inputs change just after the falling edge and outputs are sampled 1ns later.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [LW-1:0] ZLINE = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   nCompared   = 0;
  int   nMismatched = 0;
  // Model of which cache won the most recent grant: 0 = icache, 1 = dcache.
  logic expLast     = 1'b0;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia, input logic dr,
                               input logic dw, input logic [AW-1:0] da, input logic [LW-1:0] dwd);
    bus.i_read    = ir;
    bus.i_address = ia;
    bus.d_read    = dr;
    bus.d_write   = dw;
    bus.d_address = da;
    bus.d_wdata   = dwd;
  endtask

  task automatic applyMemory(input logic resp, input logic [LW-1:0] rd);
    bus.pmem_resp  = resp;
    bus.pmem_rdata = rd;
  endtask

  task automatic test_reset;
    applyStimulus(1'b1, $urandom, 1'b1, 1'b0, $urandom, rand_line());
    applyMemory(1'b1, rand_line());
    repeat (2) @(negedge clk);
    #1;
    nCompared++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata} !== {2'b00, {AW{1'b0}}, ZLINE}) begin
      nMismatched++;
      $display("FAIL reset_pmem: got %h want 0", {bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata});
    end
    nCompared++;
    if ({bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata} !== {2'b00, ZLINE, ZLINE}) begin
      nMismatched++;
      $display("FAIL reset_resp: got i=%b d=%b irdata=%h drdata=%h want all 0", bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata);
    end
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    applyMemory(1'b0, '0);
    expLast = 1'b0;
    @(negedge clk);
    #1;
    nCompared++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      nMismatched++;
      $display("FAIL reset_idle: got strobes %b want 00", {bus.pmem_read, bus.pmem_write});
    end
  endtask

  task automatic test_icache_fill;
    logic [LW-1:0] line;
    line = {32{8'hA5}};
    applyStimulus(1'b1, 32'h0000_0060, 1'b0, 1'b0, '0, '0);
    #1;
    nCompared++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      nMismatched++;
      $display("FAIL ifill_latency: got strobes %b want 00 before grant edge", {bus.pmem_read, bus.pmem_write});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      nCompared++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata, bus.i_resp} !== {2'b10, 32'h60, ZLINE, 1'b0}) begin
        nMismatched++;
        $display("FAIL ifill_serve: got rd=%b wr=%b addr=%h iresp=%b want rd=1 wr=0 addr=60 iresp=0",
                 bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.i_resp);
      end
    end
    @(negedge clk);
    applyMemory(1'b1, line);
    #1;
    nCompared++;
    if ({bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata} !== {2'b10, line, ZLINE}) begin
      nMismatched++;
      $display("FAIL ifill_resp: got i=%b d=%b irdata=%h drdata=%h want i=1 d=0 irdata=a5.. drdata=0",
               bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata);
    end
    @(negedge clk);
    applyMemory(1'b0, '0);
    bus.i_read = 1'b0;
    #1;
    nCompared++;
    if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
      nMismatched++;
      $display("FAIL ifill_done: got %b want 0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    #1;
    expLast = 1'b0;
  endtask

  task automatic test_dcache_writeback;
    logic [LW-1:0] wline;
    wline = {8{32'h1234_5678}};
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h8000_0100, wline);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.d_wdata   = rand_line();
      bus.d_address = $urandom;
      #1;
      nCompared++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata} !== {2'b01, 32'h8000_0100, wline}) begin
        nMismatched++;
        $display("FAIL dwb_serve: got rd=%b wr=%b addr=%h wdata=%h want rd=0 wr=1 addr=80000100 wdata=%h",
                 bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata, wline);
      end
    end
    @(negedge clk);
    applyMemory(1'b1, rand_line());
    #1;
    nCompared++;
    if ({bus.i_resp, bus.d_resp} !== 2'b01) begin
      nMismatched++;
      $display("FAIL dwb_resp: got i=%b d=%b want i=0 d=1", bus.i_resp, bus.d_resp);
    end
    @(negedge clk);
    applyMemory(1'b0, '0);
    bus.d_write = 1'b0;
    #1;
    nCompared++;
    if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
      nMismatched++;
      $display("FAIL dwb_done: got %b want 0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    #1;
    expLast = 1'b1;
  endtask

  task automatic test_mid_change;
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    bus.i_address = 32'hDEAD_BEE0;
    bus.i_read    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      nCompared++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_address} !== {2'b10, 32'h40}) begin
        nMismatched++;
        $display("FAIL midchg_hold: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=40", bus.pmem_read, bus.pmem_write, bus.pmem_address);
      end
      @(negedge clk);
    end
    applyMemory(1'b1, rand_line());
    #1;
    nCompared++;
    if ({bus.i_resp, bus.d_resp} !== 2'b10) begin
      nMismatched++;
      $display("FAIL midchg_resp: got i=%b d=%b want i=1 d=0", bus.i_resp, bus.d_resp);
    end
    @(negedge clk);
    applyMemory(1'b0, '0);
    @(negedge clk);
    #1;
    nCompared++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      nMismatched++;
      $display("FAIL midchg_regrant: got strobes %b want 00", {bus.pmem_read, bus.pmem_write});
    end
    expLast = 1'b0;
  endtask

  task automatic test_reset_mid;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_0200, '0);
    @(negedge clk);
    #1;
    nCompared++;
    if ({bus.pmem_read, bus.pmem_address} !== {1'b1, 32'h200}) begin
      nMismatched++;
      $display("FAIL rstmid_serve: got rd=%b addr=%h want rd=1 addr=200", bus.pmem_read, bus.pmem_address);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.d_read = 1'b0;
    applyMemory(1'b1, rand_line());
    expLast = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      nCompared++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.i_resp, bus.d_resp} !== {2'b00, {AW{1'b0}}, 2'b00}) begin
        nMismatched++;
        $display("FAIL rstmid_quiet: got rd=%b wr=%b addr=%h i=%b d=%b want all 0",
                 bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.i_resp, bus.d_resp);
      end
      @(negedge clk);
    end
    applyMemory(1'b0, '0);
    #1;
  endtask

  task automatic test_simultaneous;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] rd;
    logic          first, cur;
    for (int r = 0; r < 3; r++) begin
      ia = $urandom;
      da = $urandom;
      applyStimulus(1'b1, ia, 1'b1, 1'b0, da, '0);
`ifdef CACHE_ARBITER_RR_EN
      first = ~expLast;
`else
      first = 1'b1;
`endif
      for (int g = 0; g < 2; g++) begin
        cur = (g == 0) ? first : ~first;
        expLast = cur;
        @(negedge clk);
        #1;
        nCompared++;
        if ({bus.pmem_read, bus.pmem_write, bus.pmem_address} !== {2'b10, (cur ? da : ia)}) begin
          nMismatched++;
          $display("FAIL simul_grant r%0d g%0d: got rd=%b wr=%b addr=%h want addr=%h (%s)",
                   r, g, bus.pmem_read, bus.pmem_write, bus.pmem_address, (cur ? da : ia), (cur ? "dcache" : "icache"));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rd = rand_line();
        applyMemory(1'b1, rd);
        #1;
        nCompared++;
        if ({bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata} !== (cur ? {2'b01, ZLINE, rd} : {2'b10, rd, ZLINE})) begin
          nMismatched++;
          $display("FAIL simul_resp r%0d g%0d: got i=%b d=%b want i=%b d=%b (or rdata misrouted)",
                   r, g, bus.i_resp, bus.d_resp, ~cur, cur);
        end
        @(negedge clk);
        applyMemory(1'b0, '0);
        if (cur) bus.d_read = 1'b0;
        else     bus.i_read = 1'b0;
        #1;
        nCompared++;
        if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
          nMismatched++;
          $display("FAIL simul_done r%0d g%0d: got %b want 0000", r, g, {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
        end
        @(negedge clk);
        #1;
        nCompared++;
        if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
          nMismatched++;
          $display("FAIL simul_gap r%0d g%0d: got strobes %b want 00", r, g, {bus.pmem_read, bus.pmem_write});
        end
      end
    end
  endtask

  task automatic test_random;
    logic          iR, win;
    logic [1:0]    dK;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] dwd, rd;
    logic [1+1+AW+LW-1:0] expBus, gotBus;
    for (int it = 0; it < 40; it++) begin
      iR  = 1'($urandom_range(0, 1));
      dK  = 2'($urandom_range(0, 3));
      ia  = $urandom;
      da  = $urandom;
      dwd = rand_line();
      applyStimulus(iR, ia, dK[0], dK[1], da, dwd);
      if (!iR && dK == 2'b00) begin
        applyMemory(1'b1, rand_line());
        #1;
        nCompared++;
        if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
          nMismatched++;
          $display("FAIL rand_idle it%0d: got %b want 0000", it, {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
        end
        @(negedge clk);
        applyMemory(1'b0, '0);
        continue;
      end
`ifdef CACHE_ARBITER_RR_EN
      win = (iR && dK != 2'b00) ? ~expLast : (dK != 2'b00);
`else
      win = (dK != 2'b00);
`endif
      expLast = win;
      expBus  = win ? {~dK[1], dK[1], da, (dK[1] ? dwd : ZLINE)} : {2'b10, ia, ZLINE};
      @(negedge clk);
      for (int k = 0; k <= int'($urandom_range(0, 3)); k++) begin
        if (k > 0) begin
          @(negedge clk);
          applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, rand_line());
        end
        #1;
        gotBus = {bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata};
        nCompared++;
        if (gotBus !== expBus) begin
          nMismatched++;
          $display("FAIL rand_serve it%0d: got %h want %h", it, gotBus, expBus);
        end
      end
      @(negedge clk);
      rd = rand_line();
      applyMemory(1'b1, rd);
      #1;
      nCompared++;
      if ({bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata} !== (win ? {2'b01, ZLINE, rd} : {2'b10, rd, ZLINE})) begin
        nMismatched++;
        $display("FAIL rand_resp it%0d: got i=%b d=%b want i=%b d=%b (or rdata misrouted)", it, bus.i_resp, bus.d_resp, ~win, win);
      end
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      applyMemory(1'($urandom), rand_line());
      #1;
      nCompared++;
      if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
        nMismatched++;
        $display("FAIL rand_done it%0d: got %b want 0000", it, {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
      end
      @(negedge clk);
      applyMemory(1'b0, '0);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_icache_fill();
    test_dcache_writeback();
    test_mid_change();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache of the pipelined RV32I core.
- Sits between both caches' pmem-side interfaces and the memory/cacheline adaptor.
- Serialises whole-line (256-bit) transactions and routes the response back to the winning cache only.
- FSM-based: one transaction in flight at a time, with request capture at grant.

Parameters:
- ADDR_W, 32, physical address width.
- LINE_W, 256, cacheline width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; state resets on a clk edge while rst==0.
- i_address  in  ADDR_W  icache line address.
- i_read  in  1  icache line-fill request.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  icache transaction complete.
- d_address  in  ADDR_W  dcache line address.
- d_read  in  1  dcache line-fill request.
- d_write  in  1  dcache writeback request.
- d_wdata  in  LINE_W  dcache writeback line.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  dcache transaction complete.
- pmem_address  out  ADDR_W  address to memory.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory transaction complete.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DONE.
- Reset: state=IDLE; captured address, data, op and last-winner registers cleared. All outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- IDLE: arbitrate among pending requests (i_read; d_read|d_write).
  - On the clock edge with a request present, capture the winner's address, op and wdata, then go to SERVE_I or SERVE_D.
  - Grant latency: pmem strobe is asserted 1 cycle after the request is first seen in IDLE.
- Default arbitration: dcache has fixed priority over icache when both request in the same cycle.
- d_read and d_write asserted together is illegal; the arbiter treats it as a write.
- SERVE_x: pmem_address, pmem_read/pmem_write and pmem_wdata are driven only from the captured registers. They stay stable for the whole transaction even if the requester changes or drops its inputs.
- pmem_wdata is 0 for reads and for icache transactions.
- Response: in SERVE_x with pmem_resp=1, the matching x_resp=1 combinationally for that cycle only, with x_rdata=pmem_rdata. The other cache's resp stays 0 and its rdata stays 0. Next state is DONE.
- DONE: one dead cycle with all pmem strobes 0, so a cache can deassert its request after resp. Then IDLE.
  - Back-to-back transactions are therefore separated by at least 2 idle-strobe cycles.
- A requester dropping its request mid-transaction is ignored; the transaction completes and resp is still issued.
- pmem_resp while in IDLE or DONE is ignored; no resp is forwarded.
- Reset asserted mid-transaction: immediately IDLE, strobes drop on the next edge, and the in-flight transaction is abandoned.
- No combinational path from i_*/d_* inputs to pmem_* outputs. The only combinational paths are pmem_resp/pmem_rdata to x_resp/x_rdata.

Optional Feature:
- Macro: CACHE_ARBITER_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_winner register, reset to icache, is updated at each grant.
  - On simultaneous requests the cache that did not win last is granted.
  - Single requests are granted as normal.
- Undefined: fixed dcache priority; last_winner is not instantiated.

Decomposition:
- Shared package cache_types_pkg: arb_state_t enum (IDLE, SERVE_I, SERVE_D, DONE), arb_src_t enum (SRC_I, SRC_D), LINE_W/ADDR_W localparams.
- No sub-module; a single FSM plus capture registers is natural.

Test Plan:
- Icache fill alone: i_read=1, i_address=0x0000_0060. Expect pmem_read=1 with pmem_address=0x60 1 cycle later. Memory returns pmem_rdata=0xA5..A5 with pmem_resp after 5 cycles. Expect i_resp=1 with i_rdata=0xA5..A5 for one cycle, d_resp=0, then a DONE cycle with strobes 0.
- Dcache writeback: d_write=1, d_address=0x8000_0100, d_wdata=0x1234..  Expect pmem_write=1 with matching address and data held stable until pmem_resp; d_resp pulses once.
- Simultaneous requests, macro undefined: i_read and d_read in the same cycle. Expect dcache served first, then icache; each resp pulses exactly once.
- Simultaneous requests, CACHE_ARBITER_RR_EN defined, repeated 3 times: expect grant order D, I, D... alternation starting with D (last_winner resets to I).
- Requester changes mid-transaction: change i_address to 0xDEAD_BEE0 and drop i_read during SERVE_I. Expect pmem_address to stay at the original value and i_resp to still pulse.
- Reset mid-transaction: rst=0 during SERVE_D. Expect all outputs 0 next cycle and state IDLE. A stray pmem_resp after reset produces no x_resp.
